sram32_be_stream_initiator: RTL and testbench
=============================================

# sram32_be_stream_initiator

Initiator that drives the 1-write/1-read port pair of a banked 32-bit byte-enable SRAM wrapper (CE0/A0/D0/WE0/WEM0 write port, CE1/A1/Q1 read port) from two valid/ready request streams. It arbitrates same-bank collisions, since both ports share single-port banks. It expands byte enables into bit masks, tracks the 1-cycle SRAM read latency, and buffers read data in a credit-controlled response FIFO so the consumer can backpressure. It sits between an accelerator datapath or DMA engine and the SRAM wrapper.

## Interface
- ABITS, 14, address width, words
- DBITS, 32, data width; multiple of 8
- BANK_LSB, 13, lowest address bit of the bank index; bank = addr[ABITS-1:BANK_LSB]
- RSP_DEPTH, 2, response FIFO entries, at least 2

- CLK  in  1  clock; all state is updated on the rising edge
- RSTN  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted this cycle
- wr_addr  in  ABITS  write word address
- wr_data  in  DBITS  write data
- wr_be  in  DBITS/8  byte enables; bit i covers bits [8i+7:8i]
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  ABITS  read word address
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts rsp_data
- rsp_data  out  DBITS  read data, in request order
- CE0, A0[ABITS], D0[DBITS], WE0, WEM0[DBITS]  out  SRAM write port
- CE1, A1[ABITS]  out  SRAM read port
- Q1  in  DBITS  SRAM read data, valid the cycle after CE1

## Operation
- Handshake: a transfer occurs when valid & ready are both high at a rising edge. Once valid is asserted, request fields must stay stable until the transfer.
- Write issue is combinational in the accept cycle:
  - CE0 = WE0 = wr_valid & wr_ready.
  - A0 = wr_addr, D0 = wr_data.
  - WEM0[8i+7:8i] = {8{wr_be[i]}}.
  - When not issuing, CE0, WE0, A0, D0 and WEM0 are 0.
- Read issue is combinational in the accept cycle: CE1 = rd_valid & rd_ready, A1 = rd_addr; when not issuing, CE1 and A1 are 0.
- Bank conflict: wr_valid & rd_valid with equal bank index. Only one port may issue; the winner's ready is high and the loser's ready is low that cycle.
- Read credit: rd_ready additionally requires inflight + count − pop < RSP_DEPTH.
  - inflight is the 1-bit register that is set when a read is issued.
  - count is the FIFO occupancy.
  - pop = rsp_valid & rsp_ready.
- Capture: when inflight is 1, Q1 is pushed into the FIFO at the next edge. Overflow is impossible by construction.
- rsp_valid = (count != 0); rsp_data is the FIFO head.
- wr_ready is 1 unless the write loses arbitration.
- Reset, while RSTN is low:
  - count = 0, inflight = 0, FIFO pointers = 0, arbitration state = 0.
  - All outputs are 0, including wr_ready and rd_ready.
- Reset asserted mid-read: any in-flight response is dropped.

## Timing
- Write: request accepted in cycle T → CE0 high in cycle T; memory updated at edge T+1.
- Read: accepted in cycle T → CE1 in T → Q1 valid in T+1 → captured at edge T+2 → rsp_valid high from cycle T+2.
  - Minimum latency is 2 cycles.
  - Throughput is 1 read per cycle when rsp_ready is held high.
- FIFO full, no pop: rd_ready is low; no CE1 is issued.
- FIFO full with pop in the same cycle: a new read may still be issued.
- Non-conflicting write and read in the same cycle: both issue.

## Configuration
- SRAM32_INIT_RR_ARB_EN defined:
  - Round-robin arbitration on conflicts, using a 1-bit last-winner register (reset 0 = write treated as last winner, so the read wins the first conflict).
  - The register is updated only on cycles with a conflict.
- SRAM32_INIT_RR_ARB_EN undefined:
  - Fixed priority: the write always wins a conflict; no arbitration register exists.
- A read denied only by credit does not count as a conflict. The conflict check uses rd_valid & credit_ok.

## Test plan
- Reset with rd_valid = 1 and wr_valid = 1 → CE0 = 0, CE1 = 0, rsp_valid = 0, wr_ready = 0, rd_ready = 0.
- Write 0x0010 with data 0xDEADBEEF and wr_be = 4'b0101 → WEM0 = 0x00FF00FF. Then read 0x0010 → rsp_data = 0xDEADBEEF masked by 0x00FF00FF, with rsp_valid exactly 2 cycles after accept.
- Write 0x0005 and read 0x2005 in the same cycle (different banks, BANK_LSB = 13) → both CE0 and CE1 high that cycle.
- Write 0x0001 and read 0x0002 held for 4 cycles:
  - With RR: grants alternate R, W, R, W.
  - Without RR: the write wins every cycle and rd_ready stays 0.
- rsp_ready = 0 with rd_valid held: exactly 2 reads accepted, then rd_ready = 0. Raise rsp_ready → responses return in order and one new read is accepted per pop.
- Deassert RSTN one cycle after a read issue → no rsp_valid after reset is released; count = 0.

Source files
------------

// File: rtl/sram32_be_stream_initiator.sv
// rtl/sram32_be_stream_initiator.sv - valid/ready initiator for a banked 1W/1R byte-enable SRAM wrapper
//
// Purpose:
//   Turns a write request stream and a read request stream into SRAM
//   write-port (CE0/A0/D0/WE0/WEM0) and read-port (CE1/A1/Q1) cycles.
//   Both ports share single-port banks, so same-bank requests are
//   arbitrated. Read data (1-cycle SRAM latency) is captured into a
//   credit-controlled response FIFO so the consumer may backpressure.
//
// Optional feature:
//   SRAM32_INIT_RR_ARB_EN - round-robin arbitration on bank conflicts.
//   When undefined, the write always wins a conflict.
//
// Ports:
//   CLK, RSTN                          clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data/wr_be   write request stream
//   rd_valid/rd_ready/rd_addr                 read request stream
//   rsp_valid/rsp_ready/rsp_data              read response stream (in order)
//   CE0, A0, D0, WE0, WEM0             SRAM write port
//   CE1, A1                            SRAM read port
//   Q1                                 SRAM read data, valid the cycle after CE1

module sram32_be_stream_initiator #(
  parameter int ABITS     = 14,
  parameter int DBITS     = 32,
  parameter int BANK_LSB  = 13,
  parameter int RSP_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ABITS-1:0]   wr_addr,
  input  logic [DBITS-1:0]   wr_data,
  input  logic [DBITS/8-1:0] wr_be,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [ABITS-1:0]   rd_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DBITS-1:0]   rsp_data,
  output logic               CE0,
  output logic [ABITS-1:0]   A0,
  output logic [DBITS-1:0]   D0,
  output logic               WE0,
  output logic [DBITS-1:0]   WEM0,
  output logic               CE1,
  output logic [ABITS-1:0]   A1,
  input  logic [DBITS-1:0]   Q1
);

  localparam int BEW = DBITS / 8;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = $clog2(RSP_DEPTH);

  logic             inflight;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DBITS-1:0] fifo_mem [RSP_DEPTH];

  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic          credit_ok;
  logic          bank_eq;
  logic          conflict;
  logic          rd_wins;
  logic          wr_issue;
  logic          rd_issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = (count != '0);
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = inflight;

  // A new read is allowed only if every response already committed
  // (queued or still in the SRAM pipeline) plus this one fits the FIFO.
  // Counting this cycle's pop lets a full FIFO keep streaming.
  assign occ       = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit_ok = occ < (CW+1)'(RSP_DEPTH);

  assign bank_eq  = (wr_addr[ABITS-1:BANK_LSB] == rd_addr[ABITS-1:BANK_LSB]);
  // A read held back by credit cannot collide, so it never steals a turn.
  assign conflict = wr_valid & rd_valid & credit_ok & bank_eq;

`ifdef SRAM32_INIT_RR_ARB_EN
  logic last_rd;  // 1: read won the most recent conflict

  assign rd_wins = ~last_rd;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_rd <= 1'b0;
    end else if (conflict) begin
      last_rd <= rd_wins;
    end
  end
`else
  assign rd_wins = 1'b0;
`endif

  // Readies are forced low while reset is asserted.
  assign wr_ready = RSTN & ~(conflict & rd_wins);
  assign rd_ready = RSTN & credit_ok & ~(conflict & ~rd_wins);

  assign wr_issue = wr_valid & wr_ready;
  assign rd_issue = rd_valid & rd_ready;

  assign CE0 = wr_issue;
  assign WE0 = wr_issue;
  assign A0  = wr_issue ? wr_addr : '0;
  assign D0  = wr_issue ? wr_data : '0;
  assign CE1 = rd_issue;
  assign A1  = rd_issue ? rd_addr : '0;

  always_comb begin
    WEM0 = '0;
    for (int i = 0; i < BEW; i++) begin
      WEM0[8*i +: 8] = {8{wr_be[i] & wr_issue}};
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= rd_issue;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= Q1;
  end

endmodule

// File: tb/tb_sram32_be_stream_initiator.sv
// tb/tb_sram32_be_stream_initiator.sv - scoreboard bench for sram32_be_stream_initiator

module tb_sram32_be_stream_initiator;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        wr_valid;
  logic        wr_ready;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid;
  logic        rd_ready;
  logic [13:0] rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        CE0;
  logic [13:0] A0;
  logic [31:0] D0;
  logic        WE0;
  logic [31:0] WEM0;
  logic        CE1;
  logic [13:0] A1;
  logic [31:0] Q1;

  always #5 CLK = ~CLK;

  sram32_be_stream_initiator dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  // SRAM wrapper model: masked write, registered read (old data on same edge).
  logic [31:0] sram [0:16383];
  logic [31:0] q1_r;
  assign Q1 = q1_r;

  always @(posedge CLK) begin
    if (CE0 && WE0) sram[A0] <= (sram[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) q1_r <= sram[A1];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // Response monitor: pops one expected value per accepted response.
  always @(negedge CLK) begin
    if (RSTN && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got 0x%08h expected no response", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  logic [13:0] bp_addr [4] = '{14'h0005, 14'h0010, 14'h2005, 14'h0001};
  logic [31:0] bp_exp  [4] = '{32'h12345678, 32'h00AD00EF, 32'h00000000, 32'hA5A5A5A5};
  logic        bp_rdy  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic e_rd;
    int   k;

    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;

    // Reset with both requests asserted
    RSTN = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 14'h0010; rd_addr = 14'h0010; wr_data = 32'h0; wr_be = 4'hF;
    rsp_ready = 1'b1;
    mid();
    chk("rst_ce0", CE0, 0);
    chk("rst_ce1", CE1, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    tick(); tick();
    wr_valid = 1'b0; rd_valid = 1'b0; RSTN = 1'b1;
    tick();

    // Byte-enabled write
    wr_valid = 1'b1; wr_addr = 14'h0010; wr_data = 32'hDEADBEEF; wr_be = 4'b0101;
    mid();
    chk("wr_ready", wr_ready, 1);
    chk("wr_ce0", CE0, 1);
    chk("wr_we0", WE0, 1);
    chk("wr_a0", A0, 32'h10);
    chk("wr_d0", D0, 32'hDEADBEEF);
    chk("wr_wem0", WEM0, 32'h00FF00FF);
    tick();
    wr_valid = 1'b0;
    mid();
    chk("idle_ce0", CE0, 0);
    chk("idle_wem0", WEM0, 0);
    chk("idle_d0", D0, 0);
    tick();

    // Read back, 2-cycle latency
    rd_valid = 1'b1; rd_addr = 14'h0010;
    mid();
    chk("rd_ready", rd_ready, 1);
    chk("rd_ce1", CE1, 1);
    chk("rd_a1", A1, 32'h10);
    exp_q.push_back(32'h00AD00EF);
    tick();
    rd_valid = 1'b0;
    mid();
    chk("rd_lat_t1_valid", rsp_valid, 0);
    chk("rd_idle_ce1", CE1, 0);
    chk("rd_idle_a1", A1, 0);
    tick();
    mid();
    chk("rd_lat_t2_valid", rsp_valid, 1);
    tick();

    // Different banks, same cycle
    wr_valid = 1'b1; wr_addr = 14'h0005; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_valid = 1'b1; rd_addr = 14'h2005;
    mid();
    chk("dual_ce0", CE0, 1);
    chk("dual_ce1", CE1, 1);
    exp_q.push_back(32'h0);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    tick(); tick();

    // Same-bank conflict held for 4 cycles
    wr_valid = 1'b1; wr_addr = 14'h0001; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd_valid = 1'b1; rd_addr = 14'h0002;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM32_INIT_RR_ARB_EN
      e_rd = (i % 2 == 0);
`else
      e_rd = 1'b0;
`endif
      mid();
      chk("conf_wr_ready", wr_ready, !e_rd);
      chk("conf_rd_ready", rd_ready, e_rd);
      chk("conf_ce0", CE0, !e_rd);
      chk("conf_ce1", CE1, e_rd);
      if (e_rd) exp_q.push_back(32'h0);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (3) tick();

    // Backpressure: two reads fill the credit, then one read per pop
    rsp_ready = 1'b0;
    k = 0;
    rd_valid = 1'b1; rd_addr = bp_addr[0];
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("bp_rd_ready", rd_ready, bp_rdy[i]);
      if (bp_rdy[i]) begin
        exp_q.push_back(bp_exp[k]);
        k++;
      end
      tick();
      if (k < 4) rd_addr = bp_addr[k];
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("bp_pop_rd_ready", rd_ready, 1);
      exp_q.push_back(bp_exp[k]);
      k++;
      tick();
      if (k < 4) rd_addr = bp_addr[k];
    end
    rd_valid = 1'b0;
    repeat (4) tick();

    // Reset one cycle after a read issue drops the response
    rd_valid = 1'b1; rd_addr = 14'h0010;
    mid();
    chk("rstrd_rd_ready", rd_ready, 1);
    tick();
    rd_valid = 1'b0; RSTN = 1'b0;
    mid();
    chk("rstrd_rsp_valid_in_rst", rsp_valid, 0);
    tick(); tick();
    RSTN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("rstrd_rsp_valid", rsp_valid, 0);
      chk("rstrd_count", 32'(dut.count), 0);
      tick();
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
